// File: rtl/pll_lock_seq.sv
// PLL lock supervisor: times the PLL reset pulse, qualifies the synchronized lock and releases sys_ready.
// Build option: define PLL_LOCK_RECOVERY_EN to re-run the reset/lock sequence when lock is lost in RUN.
module pll_lock_seq #(
  parameter int RST_CYCLES    = 27,
  parameter int LOCK_TIMEOUT  = 27000,
  parameter int STABLE_CYCLES = 2700
) (
  input  logic       clkin,
  input  logic       resetn,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       sys_ready,
  output logic [3:0] retry_cnt,
  output logic       lock_err,
  output logic [1:0] dbg_state
);

  localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_P  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CNT_W  = $clog2(MAX_P) + 1;

  // The WAIT_LOCK exit edge already saw one locked cycle, so STABLE needs one fewer.
  localparam int ST_LAST_I = (STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(ST_LAST_I);

  typedef enum logic [1:0] {
    S_RST_PLL   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sync1;
  logic             r_lock_s;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pll_reset;
  logic             r_sys_ready;
  logic [3:0]       r_retry_cnt;
  logic             r_lock_err;
  logic             w_retry_inc;
  logic             w_err_set;

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= pll_lock;
      r_lock_s <= r_sync1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_retry_inc = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_RST_PLL: begin
        if (r_cnt == RST_LAST) w_state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (r_lock_s) begin
          if (STABLE_CYCLES == 1) w_state_nxt = S_RUN;
          else                    w_state_nxt = S_STABLE;
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt = S_RST_PLL;
          w_retry_inc = 1'b1;
        end
      end
      S_STABLE: begin
        if (!r_lock_s)             w_state_nxt = S_WAIT_LOCK;
        else if (r_cnt == ST_LAST) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!r_lock_s) begin
          w_err_set = 1'b1;
`ifdef PLL_LOCK_RECOVERY_EN
          w_state_nxt = S_RST_PLL;
`endif
        end
      end
      default: w_state_nxt = S_RST_PLL;
    endcase
  end

  // Outputs are decoded from the next state so they are clean flop outputs aligned with the state.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_RST_PLL;
      r_cnt       <= '0;
      r_pll_reset <= 1'b1;
      r_sys_ready <= 1'b0;
      r_retry_cnt <= 4'd0;
      r_lock_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pll_reset <= (w_state_nxt == S_RST_PLL);
      r_sys_ready <= (w_state_nxt == S_RUN);
      if (w_state_nxt != r_state)
        r_cnt <= '0;
      else if (r_state != S_RUN)
        r_cnt <= r_cnt + 1'b1;
      if (w_retry_inc && (r_retry_cnt != 4'hF))
        r_retry_cnt <= r_retry_cnt + 4'd1;
      if (w_err_set)
        r_lock_err <= 1'b1;
    end
  end

  assign pll_reset = r_pll_reset;
  assign sys_ready = r_sys_ready;
  assign retry_cnt = r_retry_cnt;
  assign lock_err  = r_lock_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Bench for pll_lock_seq: directed bring-up/retry/bounce/loss/reset cases plus random lock waveforms
// checked against a timestamp-based model of the lock sequencing rules.
module tb_pll_lock_seq;

  localparam int RST_C = 4;
  localparam int TO_C  = 20;
  localparam int ST_C  = 8;

  localparam int PH_RESETTING = 0;
  localparam int PH_SEARCHING = 1;
  localparam int PH_READY     = 2;

  logic       clkin = 1'b0;
  logic       resetn = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pll_reset;
  logic       sys_ready;
  logic [3:0] retry_cnt;
  logic       lock_err;
  logic [1:0] dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clkin = ~clkin;

  pll_lock_seq #(
    .RST_CYCLES   (RST_C),
    .LOCK_TIMEOUT (TO_C),
    .STABLE_CYCLES(ST_C)
  ) dut (
    .clkin    (clkin),
    .resetn   (resetn),
    .pll_lock (pll_lock),
    .pll_reset(pll_reset),
    .sys_ready(sys_ready),
    .retry_cnt(retry_cnt),
    .lock_err (lock_err),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [6:0] exp_q[$];
  logic       lock_q[$];

  int m_phase, m_n, m_rst_start, m_wait_start, m_run_len, m_retry;
  logic m_err;

  int   ready_edge, fall_edge, rst_fall_edge, pulse_cnt;
  logic prev_rst, prev_ready;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, m_n - 1);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    lock_q.delete();
    m_phase      = PH_RESETTING;
    m_n          = 0;
    m_rst_start  = 0;
    m_wait_start = 0;
    m_run_len    = 0;
    m_retry      = 0;
    m_err        = 1'b0;
  endtask

  // One rising edge of the reference: lock_s at edge n is the pll_lock value sampled at edge n-2.
  task automatic model_step(input logic lk);
    logic ls;
    ls = (lock_q.size() >= 2) ? lock_q[lock_q.size() - 2] : 1'b0;
    case (m_phase)
      PH_RESETTING: begin
        if (m_n - m_rst_start + 1 >= RST_C) begin
          m_phase      = PH_SEARCHING;
          m_wait_start = m_n + 1;
          m_run_len    = 0;
        end
      end
      PH_SEARCHING: begin
        if (ls) begin
          m_run_len++;
          if (m_run_len >= ST_C) m_phase = PH_READY;
        end else if (m_run_len > 0) begin
          m_run_len    = 0;
          m_wait_start = m_n + 1;
        end else if (m_n - m_wait_start + 1 >= TO_C) begin
          m_phase     = PH_RESETTING;
          m_rst_start = m_n + 1;
          if (m_retry < 15) m_retry++;
        end
      end
      default: begin
        if (!ls) begin
          m_err = 1'b1;
`ifdef PLL_LOCK_RECOVERY_EN
          m_phase     = PH_RESETTING;
          m_rst_start = m_n + 1;
          m_run_len   = 0;
`endif
        end
      end
    endcase
    lock_q.push_back(lk);
    exp_q.push_back({(m_phase == PH_RESETTING), (m_phase == PH_READY), 4'(m_retry), m_err});
    m_n++;
  endtask

  task automatic compare_outputs();
    logic [6:0] e;
    e = exp_q.pop_front();
    check_eq("pll_reset", pll_reset, e[6]);
    check_eq("sys_ready", sys_ready, e[5]);
    check_eq("retry_cnt", retry_cnt, e[4:1]);
    check_eq("lock_err",  lock_err,  e[0]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic lk);
    pll_lock = lk;
    @(posedge clkin);
    model_step(lk);
    #1;
    compare_outputs();
    if (sys_ready && !prev_ready && ready_edge < 0) ready_edge = m_n - 1;
    if (!sys_ready && prev_ready && fall_edge < 0)  fall_edge  = m_n - 1;
    if (!pll_reset && prev_rst && rst_fall_edge < 0) rst_fall_edge = m_n - 1;
    if (pll_reset && !prev_rst) pulse_cnt++;
    prev_rst   = pll_reset;
    prev_ready = sys_ready;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    #1;
    check_eq("async_pll_reset", pll_reset, 1);
    check_eq("async_sys_ready", sys_ready, 0);
    check_eq("async_retry_cnt", retry_cnt, 0);
    check_eq("async_lock_err",  lock_err,  0);
    pll_lock = 1'b0;
    repeat (2) @(posedge clkin);
    @(negedge clkin);
    resetn = 1'b1;
    model_reset();
    ready_edge    = -1;
    fall_edge     = -1;
    rst_fall_edge = -1;
    pulse_cnt     = 0;
    prev_rst      = 1'b1;
    prev_ready    = 1'b0;
  endtask

  task automatic run_pattern(input int ncyc, input int rise, input int fall, input int rise2);
    for (int n = 0; n < ncyc; n++)
      step((n >= rise) && !((n >= fall) && (n < rise2)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #3;
    apply_reset();

    // Normal bring-up: lock at cycle 10, ready visible from cycle 20.
    run_pattern(40, 10, 1000, 1000);
    check_eq("s1_rst_fall_edge", rst_fall_edge, 3);
    check_eq("s1_ready_edge", ready_edge, 19);
    check_eq("s1_pulses", pulse_cnt, 0);
    check_eq("s1_retry", retry_cnt, 0);

    // Timeout retry: no lock for 100 cycles.
    apply_reset();
    run_pattern(100, 1000, 1000, 1000);
    check_eq("s2_pulses", pulse_cnt, 4);
    check_eq("s2_retry", retry_cnt, 4);

    // Saturation.
    apply_reset();
    run_pattern(500, 1000, 1000, 1000);
    check_eq("s3_retry", retry_cnt, 15);
    check_eq("s3_ready", sys_ready, 0);

    // Lock bounce while stabilising.
    apply_reset();
    run_pattern(40, 10, 14, 16);
    check_eq("s4_ready_edge", ready_edge, 25);
    check_eq("s4_pulses", pulse_cnt, 0);

    // Lock loss 5 cycles after ready, lock returns later.
    apply_reset();
    run_pattern(70, 10, 25, 35);
    check_eq("s5_lock_err", lock_err, 1);
    check_eq("s5_retry", retry_cnt, 0);
`ifdef PLL_LOCK_RECOVERY_EN
    check_eq("s5_fall_edge", fall_edge, 27);
    check_eq("s5_pulses", pulse_cnt, 1);
`else
    check_eq("s5_fall_edge", fall_edge, -1);
    check_eq("s5_pulses", pulse_cnt, 0);
    check_eq("s5_ready_held", sys_ready, 1);
`endif

    // Reset asserted while stabilising, then a clean bring-up.
    apply_reset();
    run_pattern(16, 10, 1000, 1000);
    #2;
    apply_reset();
    run_pattern(40, 10, 1000, 1000);
    check_eq("s6_ready_edge", ready_edge, 19);
    check_eq("s6_rst_fall_edge", rst_fall_edge, 3);

    // Random lock waveforms with occasional mid-run resets.
    for (int r = 0; r < 4; r++) begin
      apply_reset();
      for (int seg = 0; seg < 12; seg++) begin
        logic lvl;
        int   len;
        lvl = 1'($urandom_range(0, 1));
        len = $urandom_range(1, 30);
        for (int k = 0; k < len; k++) step(lvl);
        if ($urandom_range(0, 15) == 0) begin
          #2;
          apply_reset();
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_seq.md
# pll_lock_seq

Lock supervisor and reset sequencer that sits directly downstream of the rPLL clock generator, running on the PLL's reference clock. It drives the PLL's active-high reset input and qualifies the raw `pll_lock` output. It releases a single `sys_ready` flag only after lock has been continuously stable for a programmed interval. It retries the PLL on lock timeout and records lock faults for the rest of the design.

## Interface

**Parameters**
- `RST_CYCLES`, default 27: cycles `pll_reset` is held high per reset attempt (1 µs at 27 MHz); must be ≥1.
- `LOCK_TIMEOUT`, default 27000: cycles allowed in WAIT_LOCK before a retry (1 ms); must be ≥1.
- `STABLE_CYCLES`, default 2700: consecutive synchronized-lock cycles required before ready (100 µs); must be ≥1.
- Counter width is `$clog2` of the largest of the three parameters, plus 1.

**Ports**
- `clkin`, input, 1: PLL reference clock (27 MHz), the only clock.
- `resetn`, input, 1: asynchronous active-low reset.
- `pll_lock`, input, 1: raw lock from the PLL; asynchronous to `clkin`.
- `pll_reset`, output, 1: active-high reset to the PLL.
- `sys_ready`, output, 1: PLL clock is valid; registered.
- `retry_cnt`, output, 4: number of lock-timeout retries; saturates at 15.
- `lock_err`, output, 1: sticky flag; set when lock is lost while in RUN.

## Operation

**Reset state** (while `resetn` = 0):
- State = RST_PLL, counter = 0.
- `pll_reset` = 1, `sys_ready` = 0, `retry_cnt` = 0, `lock_err` = 0.
- Both synchronizer flops = 0.

**Lock synchronization**
- `pll_lock` passes through a 2-flop synchronizer to produce `lock_s`.
- Only `lock_s` is used internally.

**State machine** (one counter, cleared on every state change)
- **RST_PLL**
  - `pll_reset` = 1.
  - After `RST_CYCLES` cycles in this state, go to WAIT_LOCK.
- **WAIT_LOCK**
  - `pll_reset` = 0.
  - If `lock_s` = 1, go to STABLE.
  - Otherwise, after `LOCK_TIMEOUT` cycles, go to RST_PLL and increment `retry_cnt` (saturating).
  - If lock arrives on the same cycle as the timeout, lock wins: go to STABLE, no increment.
- **STABLE**
  - If `lock_s` = 0, go to WAIT_LOCK. The counter restarts, so the timeout window restarts.
  - After `STABLE_CYCLES` consecutive cycles with `lock_s` = 1, go to RUN.
- **RUN**
  - `sys_ready` = 1.
  - If `lock_s` = 0, set `lock_err` and apply the loss handling defined under Configuration.

**Outputs**
- `pll_reset` = 1 exactly when the state is RST_PLL; registered, no glitches.
- `sys_ready` = 1 exactly when the state is RUN.

**Reset mid-operation**
- Asserting `resetn` in any state immediately (asynchronously) forces the reset state above.
- `retry_cnt` and `lock_err` are cleared only by `resetn`.

## Timing

- **First reset pulse**: after `resetn` deasserts, `pll_reset` stays high for exactly `RST_CYCLES` rising edges of `clkin`.
- **Lock visibility**: 2 cycles after `pll_lock` is sampled high, because of the synchronizer.
- **Ready latency**: `sys_ready` rises exactly 2 + `STABLE_CYCLES` edges after `pll_lock` rises, provided lock stays high throughout.
- **Retry period**: with lock never arriving, a new `pll_reset` pulse begins every `RST_CYCLES` + `LOCK_TIMEOUT` cycles.
- **Lock loss in RUN**: `sys_ready` falls 3 edges after `pll_lock` falls (2 synchronizer edges + 1 state edge). `lock_err` rises on the same edge.
- **Lock glitches**: a lock glitch shorter than one `clkin` period may be missed. Detection is not guaranteed; no filtering is required.

## Configuration

Macro: `PLL_LOCK_RECOVERY_EN`.

- **Defined**: lock loss in RUN moves the state to RST_PLL.
  - `sys_ready` drops and `lock_err` is set.
  - A full reset/lock/stable sequence then runs again.
  - `retry_cnt` is not incremented.
- **Not defined**: lock loss in RUN only sets `lock_err`.
  - The state stays RUN and `sys_ready` stays 1.
  - The PLL is never reset again until `resetn` is asserted.

## Test plan

All scenarios use `RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `STABLE_CYCLES`=8.

1. **Normal bring-up**: release `resetn`; raise `pll_lock` at cycle 10 → `pll_reset` is high for cycles 0–3; `sys_ready` rises at cycle 20; `retry_cnt` = 0.
2. **Timeout retry**: hold `pll_lock` = 0 for 100 cycles → `pll_reset` pulses begin at cycles 0, 24, 48, 72, 96; `retry_cnt` = 4.
3. **Saturation**: hold `pll_lock` = 0 for 500 cycles → `retry_cnt` stops at 15; `sys_ready` stays 0.
4. **Lock bounce in STABLE**: lock rises at cycle 10, drops at cycle 14, rises again at cycle 16 → no `pll_reset` pulse; `sys_ready` rises at cycle 26.
5. **Lock loss in RUN**: drop lock 5 cycles after ready →
   - with `PLL_LOCK_RECOVERY_EN`: `sys_ready` falls 3 cycles later, `pll_reset` is high for 4 cycles, `lock_err` = 1.
   - without it: `sys_ready` stays 1, `lock_err` = 1.
6. **Reset mid-sequence**: assert `resetn` = 0 during STABLE → all outputs return to their reset values asynchronously (`pll_reset` = 1, `sys_ready` = 0, `retry_cnt` = 0, `lock_err` = 0); after release, the sequence matches scenario 1.
